maze_walker_dp: RTL and testbench
=================================

// Module: maze_walker_dp
// PURPOSE
//  Parametrised successor to the maze-solver datapath. Holds the current (x,y)
//  location, computes the next location from a direction or from the top of a
//  backtrack stack, and flags goal and edge conditions to the controller FSM.
//  Adds over the previous generation: configurable coordinate width and stack
//  depth, edge (wrap) blocking, full/underflow protection, a move counter and
//  synchronous clear.
// PARAMETERS
//  CW      4    coordinate width in bits (x and y each)
//  DEPTH   16   backtrack stack depth in entries (power of 2, >=2)
//  CNTW    16   move counter width
//  GOAL_X  0    goal x coordinate (CW bits)
//  GOAL_Y  0    goal y coordinate (CW bits)
// PORTS
//  clk        in   1        clock, all state on posedge
//  rst        in   1        asynchronous, active-low reset
//  clr        in   1        sync clear: cur, stack, flags, counter -> 0
//  ld         in   1        load nxt into cur at posedge
//  dir        in   2        00:y-1  01:x+1  10:x-1  11:y+1
//  step_en    in   1        nxt = cur moved one cell along dir
//  push       in   1        push cur onto stack
//  pop        in   1        nxt = stack top; remove it (on ld or alone)
//  cur_x      out  CW       current x
//  cur_y      out  CW       current y
//  nxt_x      out  CW       next x (combinational)
//  nxt_y      out  CW       next y (combinational)
//  at_goal    out  1        cur == {GOAL_X,GOAL_Y}
//  edge_blk   out  1        step_en && move would leave grid (comb.)
//  stk_empty  out  1        stack count == 0
//  stk_full   out  1        stack count == DEPTH
//  stk_cnt    out  log2(DEPTH)+1  entries held
//  ovf_err    out  1        sticky: push attempted while full
//  unf_err    out  1        sticky: pop attempted while empty
//  move_cnt   out  CNTW     loads that changed cur; saturates at all-ones
// BEHAVIOUR
//  - Reset (rst=0, async): cur=0, stack empty, ovf/unf=0, move_cnt=0.
//    Outputs valid from the cycle after release; no reset-time stack writes.
//  - nxt priority (comb.): clr -> 0; pop && !empty -> top; step_en && !edge_blk
//    -> moved cur; else cur. Direction adds +/-1 on one axis only.
//  - edge_blk=1 when x==0&&dir=10, x==max&&dir=01, y==0&&dir=00,
//    y==max&&dir=11 (max = 2^CW-1). Coordinates never wrap; nxt = cur.
//  - ld: cur <= nxt at posedge (1-cycle latency). Without ld cur holds.
//  - Stack top = last pushed entry, readable combinationally same cycle.
//  - push only: mem[cnt]<=cur, cnt++. If full: ignored, ovf_err<=1.
//  - pop only: cnt-- at posedge (independent of ld). If empty: ignored,
//    unf_err<=1, nxt=cur.
//  - push&&pop, non-empty: top replaced by cur, cnt unchanged, nxt=old top
//    (swap). push&&pop, empty: push only, unf_err<=1.
//  - move_cnt++ on posedge with ld && nxt!=cur && !clr; holds at 2^CNTW-1.
//  - clr (sync) overrides push/pop/ld; takes effect next posedge.
//  - Reset mid-operation: all state cleared immediately, stack contents
//    discarded; outputs show reset values while rst=0.
// TESTING
//  1 Reset, step_en dir=01 ld x4 -> cur=(4,0), move_cnt=4, no flags.
//  2 cur=(0,0): dir=10 and dir=00 with ld -> edge_blk=1, cur stays (0,0),
//    move_cnt unchanged; cur=(15,15) dir=01/11 likewise.
//  3 Push (1,0),(2,0),(3,0); pop+ld x3 -> cur=(3,0),(2,0),(1,0), stk_empty=1.
//  4 Push DEPTH+1 times -> stk_full=1 after DEPTH, ovf_err=1, cnt=DEPTH;
//    pop on empty -> unf_err=1, cur unchanged; clr -> both flags 0.
//  5 Stack top (5,5), cur=(6,5), push&pop&ld -> cur=(5,5), top=(6,5), cnt same.
//  6 GOAL=(2,3): walk there -> at_goal=1 exactly when cur=(2,3); assert rst
//    mid-walk -> cur=0, stk_cnt=0, move_cnt=0 without waiting for clk.

Source files
------------

// File: rtl/maze_walker_dp_if.sv
// maze_walker_dp_if: controller-to-datapath bundle for the maze walker.
interface maze_walker_dp_if #(
  parameter int CW    = 4,
  parameter int DEPTH = 16,
  parameter int CNTW  = 16
);
  localparam int SW = $clog2(DEPTH) + 1;
  logic          clr;
  logic          ld;
  logic [1:0]    dir;
  logic          step_en;
  logic          push;
  logic          pop;
  logic [CW-1:0] cur_x;
  logic [CW-1:0] cur_y;
  logic [CW-1:0] nxt_x;
  logic [CW-1:0] nxt_y;
  logic          at_goal;
  logic          edge_blk;
  logic          stk_empty;
  logic          stk_full;
  logic [SW-1:0] stk_cnt;
  logic          ovf_err;
  logic          unf_err;
  logic [CNTW-1:0] move_cnt;
  modport master (
    output clr, ld, dir, step_en, push, pop,
    input  cur_x, cur_y, nxt_x, nxt_y, at_goal, edge_blk,
           stk_empty, stk_full, stk_cnt, ovf_err, unf_err, move_cnt
  );
  modport slave (
    input  clr, ld, dir, step_en, push, pop,
    output cur_x, cur_y, nxt_x, nxt_y, at_goal, edge_blk,
           stk_empty, stk_full, stk_cnt, ovf_err, unf_err, move_cnt
  );
endinterface

// File: rtl/maze_walker_dp.sv
// maze_walker_dp: maze walker location register, next-cell logic, backtrack stack and move counter.
module maze_walker_dp #(
  parameter int            CW     = 4,
  parameter int            DEPTH  = 16,
  parameter int            CNTW   = 16,
  parameter logic [CW-1:0] GOAL_X = '0,
  parameter logic [CW-1:0] GOAL_Y = '0
) (
  input logic             clk,
  input logic             rst,
  maze_walker_dp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;
  localparam logic [CW-1:0] MAXC = '1;
  logic [2*CW-1:0] mem [DEPTH];
  logic [CW-1:0]   cx, cy, mx, my, nx, ny;
  logic [SW-1:0]   cnt;
  logic [AW-1:0]   ti, wa;
  logic [2*CW-1:0] top;
  logic [CNTW-1:0] mc;
  logic            empty, full, eb, swap, we, ovf, unf;
  always_comb begin
    empty = cnt == '0;
    full  = cnt == SW'(DEPTH);
    ti    = cnt[AW-1:0] - AW'(1);
    top   = mem[ti];
    eb    = bus.step_en && ((bus.dir == 2'b00 && cy == '0) || (bus.dir == 2'b01 && cx == MAXC) ||
                            (bus.dir == 2'b10 && cx == '0) || (bus.dir == 2'b11 && cy == MAXC));
    mx    = bus.dir == 2'b01 ? cx + CW'(1) : bus.dir == 2'b10 ? cx - CW'(1) : cx;
    my    = bus.dir == 2'b11 ? cy + CW'(1) : bus.dir == 2'b00 ? cy - CW'(1) : cy;
    {nx, ny} = bus.clr ? '0 : (bus.pop && !empty) ? top :
               (bus.step_en && !eb) ? {mx, my} : {cx, cy};
    swap  = bus.push && bus.pop && !empty;
    // rst gate keeps the stack untouched while reset is held
    we    = rst && !bus.clr && bus.push && (swap || !full);
    wa    = swap ? ti : cnt[AW-1:0];
  end
  always_ff @(posedge clk)
    if (we) mem[wa] <= {cx, cy};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {cx, cy} <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      mc       <= '0;
    end else if (bus.clr) begin
      {cx, cy} <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      mc       <= '0;
    end else begin
      if (bus.ld) begin
        {cx, cy} <= {nx, ny};
        if ({nx, ny} != {cx, cy} && mc != '1) mc <= mc + CNTW'(1);
      end
      if (bus.push && !swap) begin
        if (full) ovf <= 1'b1;
        else cnt <= cnt + SW'(1);
      end else if (bus.pop && !bus.push && !empty) cnt <= cnt - SW'(1);
      if (bus.pop && empty) unf <= 1'b1;
    end
  end
  assign bus.cur_x     = cx;
  assign bus.cur_y     = cy;
  assign bus.nxt_x     = nx;
  assign bus.nxt_y     = ny;
  assign bus.at_goal   = cx == GOAL_X && cy == GOAL_Y;
  assign bus.edge_blk  = eb;
  assign bus.stk_empty = empty;
  assign bus.stk_full  = full;
  assign bus.stk_cnt   = cnt;
  assign bus.ovf_err   = ovf;
  assign bus.unf_err   = unf;
  assign bus.move_cnt  = mc;
endmodule

// File: tb/tb_maze_walker_dp.sv
// tb_maze_walker_dp: directed scenarios plus randomized ops checked against a queue-based model.
module tb_maze_walker_dp;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  maze_walker_dp_if #(.CW(4), .DEPTH(16), .CNTW(16)) bus ();
  maze_walker_dp #(.CW(4), .DEPTH(16), .CNTW(16), .GOAL_X(4'd2), .GOAL_Y(4'd3)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  logic [7:0]  q[$];
  int          m_x, m_y, m_mc;
  logic        m_ovf, m_unf;
  logic        eb_s, m_eb_s;
  logic [7:0]  nxt_s, m_nxt_s;
  task automatic m_reset();
    m_x = 0; m_y = 0; m_mc = 0; m_ovf = 0; m_unf = 0;
    q.delete();
  endtask
  function automatic logic m_blocked(input logic s, input logic [1:0] d);
    int tx, ty;
    tx = m_x + (d == 2'd1 ? 1 : d == 2'd2 ? -1 : 0);
    ty = m_y + (d == 2'd3 ? 1 : d == 2'd0 ? -1 : 0);
    return s && (tx < 0 || tx > 15 || ty < 0 || ty > 15);
  endfunction
  function automatic logic [7:0] m_next(input logic c, input logic [1:0] d, input logic s, input logic po);
    int tx, ty;
    tx = m_x + (d == 2'd1 ? 1 : d == 2'd2 ? -1 : 0);
    ty = m_y + (d == 2'd3 ? 1 : d == 2'd0 ? -1 : 0);
    if (c) return 8'h00;
    if (po && q.size() > 0) return q[$];
    if (s && !m_blocked(s, d)) return {tx[3:0], ty[3:0]};
    return {m_x[3:0], m_y[3:0]};
  endfunction
  task automatic m_tick(input logic c, l, input logic [1:0] d, input logic s, pu, po);
    logic [7:0] n, old;
    n = m_next(c, d, s, po);
    old = {m_x[3:0], m_y[3:0]};
    if (c) begin
      m_reset();
      return;
    end
    if (l) begin
      if (n != old && m_mc != 65535) m_mc++;
      m_x = int'(n[7:4]); m_y = int'(n[3:0]);
    end
    if (pu && po) begin
      if (q.size() > 0) q[q.size()-1] = old;
      else begin q.push_back(old); m_unf = 1; end
    end else if (pu) begin
      if (q.size() == 16) m_ovf = 1; else q.push_back(old);
    end else if (po) begin
      if (q.size() == 0) m_unf = 1; else void'(q.pop_back());
    end
  endtask
  task automatic apply(input logic c, l, input logic [1:0] d, input logic s, pu, po);
    bus.clr = c; bus.ld = l; bus.dir = d; bus.step_en = s; bus.push = pu; bus.pop = po;
    #1;
    eb_s = bus.edge_blk;
    nxt_s = {bus.nxt_x, bus.nxt_y};
    m_eb_s = m_blocked(s, d);
    m_nxt_s = m_next(c, d, s, po);
    @(posedge clk);
    m_tick(c, l, d, s, pu, po);
    #1;
    bus.clr = 0; bus.ld = 0; bus.dir = 0; bus.step_en = 0; bus.push = 0; bus.pop = 0;
  endtask
  task automatic walk(input logic [1:0] d, input int n);
    for (int i = 0; i < n; i++) apply(0, 1, d, 1, 0, 0);
  endtask
  task automatic test_reset();
    #3;
    checks++;
    if ({bus.cur_x, bus.cur_y, bus.stk_cnt, bus.stk_empty, bus.ovf_err, bus.unf_err, bus.move_cnt} !== {8'h00, 5'd0, 1'b1, 2'b00, 16'd0}) begin
      errors++; $display("FAIL reset_held cur=%h cnt=%0d emp=%b mc=%0d", {bus.cur_x, bus.cur_y}, bus.stk_cnt, bus.stk_empty, bus.move_cnt);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    m_reset();
    checks++;
    if ({bus.cur_x, bus.cur_y, bus.stk_cnt, bus.stk_full, bus.move_cnt} !== {8'h00, 5'd0, 1'b0, 16'd0}) begin
      errors++; $display("FAIL reset_release cur=%h cnt=%0d mc=%0d", {bus.cur_x, bus.cur_y}, bus.stk_cnt, bus.move_cnt);
    end
  endtask
  task automatic test_walk();
    walk(2'b01, 4);
    checks++;
    if ({bus.cur_x, bus.cur_y, bus.move_cnt, bus.ovf_err, bus.unf_err, bus.at_goal} !== {4'd4, 4'd0, 16'd4, 3'b000}) begin
      errors++; $display("FAIL walk cur=(%0d,%0d) mc=%0d flags=%b%b%b required (4,0) mc=4 flags=000", bus.cur_x, bus.cur_y, bus.move_cnt, bus.ovf_err, bus.unf_err, bus.at_goal);
    end
  endtask
  task automatic test_edge();
    logic [1:0] ds [4] = '{2'b10, 2'b00, 2'b01, 2'b11};
    apply(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) walk(2'b01, 15);
      if (i == 2) walk(2'b11, 15);
      apply(0, 1, ds[i], 1, 0, 0);
      checks++;
      if ({eb_s, bus.cur_x, bus.cur_y, bus.move_cnt} !== {1'b1, (i < 2 ? 8'h00 : 8'hff), (i < 2 ? 16'd0 : 16'd30)}) begin
        errors++; $display("FAIL edge dir=%b eb=%b cur=(%0d,%0d) mc=%0d", ds[i], eb_s, bus.cur_x, bus.cur_y, bus.move_cnt);
      end
    end
  endtask
  task automatic test_stack();
    apply(1, 0, 0, 0, 0, 0);
    apply(0, 1, 2'b01, 1, 0, 0);
    apply(0, 1, 2'b01, 1, 1, 0);
    apply(0, 1, 2'b01, 1, 1, 0);
    apply(0, 0, 0, 0, 1, 0);
    checks++;
    if (bus.stk_cnt !== 5'd3) begin errors++; $display("FAIL stack_cnt got %0d required 3", bus.stk_cnt); end
    for (int i = 3; i >= 1; i--) begin
      apply(0, 1, 0, 0, 0, 1);
      checks++;
      if ({bus.cur_x, bus.cur_y} !== {i[3:0], 4'd0}) begin
        errors++; $display("FAIL stack_pop cur=(%0d,%0d) required (%0d,0)", bus.cur_x, bus.cur_y, i);
      end
    end
    checks++;
    if (bus.stk_empty !== 1'b1) begin errors++; $display("FAIL stack_empty got %b required 1", bus.stk_empty); end
  endtask
  task automatic test_overflow();
    apply(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 17; i++) begin
      apply(0, 0, 0, 0, 1, 0);
      if (i == 16) begin
        checks++;
        if ({bus.stk_full, bus.ovf_err} !== 2'b10) begin errors++; $display("FAIL full_at_depth full=%b ovf=%b required 1 0", bus.stk_full, bus.ovf_err); end
      end
    end
    checks++;
    if ({bus.ovf_err, bus.stk_cnt} !== {1'b1, 5'd16}) begin errors++; $display("FAIL overflow ovf=%b cnt=%0d required 1 16", bus.ovf_err, bus.stk_cnt); end
    for (int i = 0; i < 16; i++) apply(0, 0, 0, 0, 0, 1);
    apply(0, 1, 0, 0, 0, 1);
    checks++;
    if ({bus.unf_err, bus.cur_x, bus.cur_y, bus.stk_empty} !== {1'b1, 8'h00, 1'b1}) begin
      errors++; $display("FAIL underflow unf=%b cur=(%0d,%0d) emp=%b", bus.unf_err, bus.cur_x, bus.cur_y, bus.stk_empty);
    end
    apply(1, 0, 0, 0, 0, 0);
    checks++;
    if ({bus.ovf_err, bus.unf_err} !== 2'b00) begin errors++; $display("FAIL clr_flags ovf=%b unf=%b required 00", bus.ovf_err, bus.unf_err); end
  endtask
  task automatic test_swap();
    apply(1, 0, 0, 0, 0, 0);
    walk(2'b01, 5);
    walk(2'b11, 5);
    apply(0, 0, 0, 0, 1, 0);
    walk(2'b01, 1);
    apply(0, 1, 0, 0, 1, 1);
    checks++;
    if ({bus.cur_x, bus.cur_y, bus.stk_cnt} !== {8'h55, 5'd1}) begin
      errors++; $display("FAIL swap cur=(%0d,%0d) cnt=%0d required (5,5) 1", bus.cur_x, bus.cur_y, bus.stk_cnt);
    end
    apply(0, 0, 0, 0, 0, 1);
    checks++;
    if ({nxt_s, bus.stk_cnt} !== {8'h65, 5'd0}) begin
      errors++; $display("FAIL swap_top nxt=%h cnt=%0d required 65 0", nxt_s, bus.stk_cnt);
    end
  endtask
  task automatic test_random();
    logic c, l, s, pu, po;
    logic [1:0] d;
    int pb;
    apply(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      pb = ((i / 60) % 2 == 0) ? 80 : 20;
      c = $urandom_range(0, 79) == 0;
      l = $urandom_range(0, 3) != 0;
      d = 2'($urandom_range(0, 3));
      s = $urandom_range(0, 3) != 0;
      pu = $urandom_range(0, 99) < pb;
      po = $urandom_range(0, 99) < 100 - pb;
      apply(c, l, d, s, pu, po);
      checks++;
      if ({eb_s, nxt_s} !== {m_eb_s, m_nxt_s}) begin
        errors++; $display("FAIL rand_comb i=%0d eb=%b nxt=%h required eb=%b nxt=%h", i, eb_s, nxt_s, m_eb_s, m_nxt_s);
      end
      checks++;
      if ({bus.cur_x, bus.cur_y, bus.stk_cnt, bus.stk_empty, bus.stk_full, bus.ovf_err, bus.unf_err, bus.move_cnt, bus.at_goal} !==
          {m_x[3:0], m_y[3:0], 5'(q.size()), q.size() == 0, q.size() == 16, m_ovf, m_unf, m_mc[15:0], m_x == 2 && m_y == 3}) begin
        errors++; $display("FAIL rand_state i=%0d cur=(%0d,%0d) cnt=%0d ovf=%b unf=%b mc=%0d required (%0d,%0d) cnt=%0d ovf=%b unf=%b mc=%0d",
          i, bus.cur_x, bus.cur_y, bus.stk_cnt, bus.ovf_err, bus.unf_err, bus.move_cnt, m_x, m_y, q.size(), m_ovf, m_unf, m_mc);
      end
    end
  endtask
  task automatic test_goal();
    int ex, ey;
    logic [1:0] path [6] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
    apply(1, 0, 0, 0, 0, 0);
    ex = 0; ey = 0;
    foreach (path[i]) begin
      apply(0, 1, path[i], 1, 1, 0);
      if (path[i] == 2'b01) ex++; else ey++;
      checks++;
      if (bus.at_goal !== (ex == 2 && ey == 3)) begin
        errors++; $display("FAIL goal at (%0d,%0d) at_goal=%b required %b", ex, ey, bus.at_goal, ex == 2 && ey == 3);
      end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.cur_x, bus.cur_y, bus.stk_cnt, bus.move_cnt} !== {8'h00, 5'd0, 16'd0}) begin
      errors++; $display("FAIL async_reset cur=(%0d,%0d) cnt=%0d mc=%0d required all 0", bus.cur_x, bus.cur_y, bus.stk_cnt, bus.move_cnt);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    m_reset();
    apply(0, 1, 0, 0, 0, 1);
    checks++;
    if ({bus.unf_err, bus.cur_x, bus.cur_y} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL reset_discard unf=%b cur=(%0d,%0d) required 1 (0,0)", bus.unf_err, bus.cur_x, bus.cur_y);
    end
  endtask
  initial begin
    bus.clr = 0; bus.ld = 0; bus.dir = 0; bus.step_en = 0; bus.push = 0; bus.pop = 0;
    test_reset();
    test_walk();
    test_edge();
    test_stack();
    test_overflow();
    test_swap();
    test_random();
    test_goal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
